// File: rtl/seven_seg_scan_display.sv
// Signed decimal driver for a time-multiplexed common-anode 7-segment bank:
// clamp -> sequential double-dabble -> atomic commit, with a free-running digit scanner.

module seven_seg_digit_dec (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = 7'h40;
                4'd1:    seg = 7'h79;
                4'd2:    seg = 7'h24;
                4'd3:    seg = 7'h30;
                4'd4:    seg = 7'h19;
                4'd5:    seg = 7'h12;
                4'd6:    seg = 7'h02;
                4'd7:    seg = 7'h78;
                4'd8:    seg = 7'h00;
                4'd9:    seg = 7'h10;
                default: seg = 7'h7F;
            endcase
        end
    end
endmodule

module seven_seg_scan_display #(
    parameter int DATA_W     = 16,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int LZ_BLANK   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  done,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);
    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint MAXV     = pow10(NUM_DIGITS) - 1;
    // When the bound exceeds the signed input range no input can reach it.
    localparam bit     CLAMP_EN = MAXV <= ((longint'(1) <<< (DATA_W - 1)) - 1);
    localparam logic signed [DATA_W:0] MAXV_S = CLAMP_EN ? (DATA_W+1)'(MAXV) : '0;
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, CLAMP, SHIFT, COMMIT} state_t;

    state_t                         state;
    logic [DATA_W-1:0]              data_q;
    logic [DATA_W-1:0]              mag_q;
    logic [CNT_W-1:0]               cnt;
    logic [NUM_DIGITS-1:0][3:0]     bcd_q, bcd_adj, dig_q;
    logic                           sign_w, sign_q;

    logic signed [DATA_W:0]         ext, clamped;
    logic [DATA_W-1:0]              mag_c;

    // The extra bit keeps |most negative input| representable.
    always_comb begin
        ext     = {data_q[DATA_W-1], data_q};
        clamped = ext;
        if (CLAMP_EN && (ext > MAXV_S))
            clamped = MAXV_S;
        else if (CLAMP_EN && (ext < -MAXV_S))
            clamped = -MAXV_S;
        mag_c = clamped[DATA_W] ? DATA_W'(-clamped) : DATA_W'(clamped);
    end

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++)
            bcd_adj[k] = (bcd_q[k] >= 4'd5) ? bcd_q[k] + 4'd3 : bcd_q[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            done     <= 1'b0;
            data_q   <= '0;
            mag_q    <= '0;
            cnt      <= '0;
            bcd_q    <= '0;
            sign_w   <= 1'b0;
            dig_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= CLAMP;
                    end
                end
                CLAMP: begin
                    mag_q  <= mag_c;
                    sign_w <= clamped[DATA_W];
                    bcd_q  <= '0;
                    cnt    <= CNT_W'(DATA_W - 1);
                    state  <= SHIFT;
                end
                SHIFT: begin
                    bcd_q <= BCD_W'({bcd_adj, mag_q[DATA_W-1]});
                    mag_q <= mag_q << 1;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == '0) state <= COMMIT;
                end
                COMMIT: begin
                    dig_q    <= bcd_q;
                    sign_q   <= sign_w;
                    done     <= 1'b1;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [NUM_DIGITS-1:0]      blank;
    logic [NUM_DIGITS-1:0][6:0] seg_all;

    // A digit blanks only if it and everything above it are zero; units never blanks.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (dig_q[k] == 4'd0);
            if (k != 0) blank[k] = (LZ_BLANK != 0) && zero_run;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        seven_seg_digit_dec u_dec (
            .bcd   (dig_q[k]),
            .blank (blank[k]),
            .seg   (seg_all[k])
        );
    end

    logic [PRE_W-1:0] pre;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
            seg <= 7'h7F;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            if (pre == PRE_W'(SCAN_DIV - 1)) begin
                pre <= '0;
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                pre <= pre + PRE_W'(1);
            end
            seg <= seg_all[idx];
            an  <= ~(NUM_DIGITS'(1) << idx);
            dp  <= ~(sign_q && (idx == IDX_W'(NUM_DIGITS - 1)));
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_display.sv
// Randomized bench for seven_seg_scan_display against an arithmetic reference model;
// two DUTs share stimulus, one with leading-zero blanking and one without.

module tb_seven_seg_scan_display;
    localparam int DW = 16, ND = 4, SD = 4, MAXV = 9999;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          ready1, done1, dp1, ready0, done0, dp0;
    logic [6:0]    seg1, seg0;
    logic [ND-1:0] an1, an0;

    int n_cmp = 0, n_err = 0;
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seven_seg_scan_display #(.DATA_W(DW), .NUM_DIGITS(ND), .SCAN_DIV(SD), .LZ_BLANK(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ready1),
        .done(done1), .seg(seg1), .dp(dp1), .an(an1));

    seven_seg_scan_display #(.DATA_W(DW), .NUM_DIGITS(ND), .SCAN_DIV(SD), .LZ_BLANK(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ready0),
        .done(done0), .seg(seg0), .dp(dp0), .an(an0));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        if (v > MAXV) return MAXV;
        if (v < -MAXV) return -MAXV;
        return v;
    endfunction

    function automatic logic [6:0] seg_of(input int v, input int k, input bit lz);
        int mag, p;
        mag = (v < 0) ? -v : v;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (lz && k > 0 && mag < p) return 7'h7F;
        return seg_tab[(mag / p) % 10];
    endfunction

    // Reference model: value-level display contents plus handshake/latency timing.
    int m_tick = 0, m_idx = 0, m_left = 0, m_pend = 0, m_com = 0;
    int m_accepts = 0, m_dones = 0;
    logic          e_ready = 1'b1, e_done = 1'b0, e_dp = 1'b1;
    logic [6:0]    e_seg1 = 7'h7F, e_seg0 = 7'h7F;
    logic [ND-1:0] e_an = '1;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_tick = 0; m_idx = 0; m_left = 0; m_com = 0;
            e_ready = 1'b1; e_done = 1'b0; e_dp = 1'b1;
            e_seg1 = 7'h7F; e_seg0 = 7'h7F; e_an = '1;
        end else begin
            e_an   = ~(ND'(1) << m_idx);
            e_seg1 = seg_of(m_com, m_idx, 1'b1);
            e_seg0 = seg_of(m_com, m_idx, 1'b0);
            e_dp   = !((m_idx == ND - 1) && (m_com < 0));
            e_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_com = m_pend; e_done = 1'b1; e_ready = 1'b1; m_dones++;
                end
            end else if (e_ready && in_valid) begin
                m_pend = clampv(int'($signed(in_data)));
                m_left = DW + 2; e_ready = 1'b0; m_accepts++;
            end
            m_tick++;
            m_idx = (m_tick / SD) % ND;
        end
    end

    bit chk_en = 1'b0;
    int d_dones = 0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            if (done1 === 1'b1) d_dones++;
            chk("in_ready", 32'(ready1), 32'(e_ready));
            chk("done",     32'(done1),  32'(e_done));
            chk("seg",      32'(seg1),   32'(e_seg1));
            chk("dp",       32'(dp1),    32'(e_dp));
            chk("an",       32'(an1),    32'(e_an));
            chk("in_ready_nolz", 32'(ready0), 32'(e_ready));
            chk("done_nolz",     32'(done0),  32'(e_done));
            chk("seg_nolz",      32'(seg0),   32'(e_seg0));
            chk("dp_nolz",       32'(dp0),    32'(e_dp));
            chk("an_nolz",       32'(an0),    32'(e_an));
        end
    end

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_accepts(input int start, input int want);
        for (int i = 0; i < 200 && (m_accepts - start) < want; i++) tick(1);
    endtask

    task automatic send(input int v);
        int start;
        start    = m_accepts;
        in_data  = DW'(v);
        in_valid = 1'b1;
        wait_accepts(start, 1);
        in_valid = 1'b0;
        chk("accept", 32'(m_accepts - start), 32'd1);
    endtask

    localparam int SETTLE = DW + 2 + ND * SD + 4;

    initial begin
        int start, v;
        tick(2);
        chk_en = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(ND * SD * 2);

        foreach (seg_tab[i]) begin end
        send(-1234);  tick(SETTLE);
        send(32767);  tick(SETTLE);
        send(-32768); tick(SETTLE);
        send(-5);     tick(SETTLE);
        send(0);      tick(SETTLE);

        // 42 held through the conversion, then swapped for 7 while busy
        start    = m_accepts;
        in_data  = DW'(42);
        in_valid = 1'b1;
        wait_accepts(start, 1);
        tick(5);
        in_data = DW'(7);
        wait_accepts(start, 2);
        in_valid = 1'b0;
        chk("accept_42_7", 32'(m_accepts - start), 32'd2);
        tick(SETTLE);

        // reset in the middle of a conversion
        send(5555);
        tick(6);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(SETTLE);

        for (int r = 0; r < 30; r++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($signed(DW'($urandom)));
                1:       v = int'($urandom_range(0, 2000)) - 1000;
                2:       v = int'($urandom_range(0, 30)) - 15;
                default: v = int'($urandom_range(0, 20000)) - 10000;
            endcase
            send(v);
            tick(int'($urandom_range(0, 40)));
        end
        tick(SETTLE);

        chk("done_count", 32'(d_dones), 32'(m_dones));
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_display.md
Name: seven_seg_scan_display

Overview:
- Parametrised signed decimal display driver for an N-digit, time-multiplexed, common-anode 7-segment bank.
- Accepts a signed DATA_W-bit value over a valid/ready handshake and clamps it to ±(10^NUM_DIGITS−1).
- Converts the magnitude to BCD with a sequential shift-add-3 (double-dabble) engine.
- Scans the digits continuously. The sign is shown on the most significant digit's decimal point.
- Sits between the SPI receive register and the board display pins.

Parameters:
- DATA_W, 16: width of the signed input; 4..32.
- NUM_DIGITS, 4: number of digit positions; 1..8. The clamp bound (10^NUM_DIGITS−1) must fit in DATA_W−1 bits, or the clamp is disabled by elaboration check.
- SCAN_DIV, 1000: clock cycles per digit slot; ≥2.
- LZ_BLANK, 1: 1 blanks leading zeros above the most significant non-zero digit. The units digit is never blanked.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_data, input, DATA_W: signed two's-complement value.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: converter idle; a transfer occurs when in_valid && in_ready.
- done, output, 1: one-cycle pulse when a new value is committed to the display.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- dp, output, 1: decimal point, active-low.
- an, output, NUM_DIGITS: digit enables, active-low, one-hot; bit 0 is the units digit.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, done=0.
  - Committed BCD digits=0, committed sign=0.
  - Scan prescaler=0, digit index=0.
  - seg=7'h7F, dp=1, an=all ones.
  - Reset mid-conversion aborts the conversion; the display resumes showing 0.
- FSM states: IDLE → CLAMP → SHIFT → COMMIT → IDLE.
  - IDLE: in_ready=1. On a transfer, capture in_data and go to CLAMP. in_ready drops the next cycle.
  - CLAMP (1 cycle):
    - If value > MAXV then val=MAXV; if value < −MAXV then val=−MAXV; MAXV=10^NUM_DIGITS−1.
    - neg = val<0.
    - mag = |val|, computed at DATA_W+1 bits so the most negative input cannot overflow.
  - SHIFT (DATA_W cycles): one double-dabble iteration per cycle. Any BCD nibble ≥5 gets +3 before the left shift; the mag MSB shifts in. An iteration counter counts DATA_W−1 down to 0.
  - COMMIT (1 cycle): the BCD digits and neg load atomically into the committed display registers; done=1. Return to IDLE; in_ready=1 in the following cycle.
- Latency: accept edge T → committed registers valid and done high at cycle T+DATA_W+2. The display never shows a partially converted value.
- in_valid while in_ready=0 is ignored. The sender holds; there is no buffering and no drop flag.
- Scan:
  - The prescaler counts 0..SCAN_DIV−1 and wraps.
  - On wrap, the digit index advances 0→NUM_DIGITS−1→0.
  - The scan runs independently of the FSM and never stalls.
- Outputs are registered from the digit index and committed data. They change one cycle after the index changes. an = ~(1<<index).
- seg:
  - BCD 0..9 maps to 40,79,24,30,19,12,02,78,00,10 (hex, active-low).
  - Blanked or illegal nibble gives 7F.
  - With LZ_BLANK=1, digit k>0 is blanked when it and every digit above it are zero.
- dp=0 only when index=NUM_DIGITS−1 and the committed sign is negative; otherwise dp=1.
  - The sign stays on the top position even when that digit is blanked.
  - Committed zero is always positive.

Test Plan:
- Reset, no input → after 1 cycle an cycles 1110,1101,1011,0111 every SCAN_DIV clocks. seg=40 on units, 7F on the others (LZ_BLANK=1); dp=1 throughout.
- Send in_data=−1234 at T → in_ready=0 from T+1; done at T+18 (DATA_W=16). Digits show 4,3,2,1 on an bits 0..3; dp=0 only on an=0111.
- Send 32767, then −32768 → both clamp; display 9999 with dp=1, then 9999 with dp=0 on the top digit.
- in_valid held with 42 then 7 during SHIFT → 7 not accepted until in_ready=1. Display goes 42 (digits 3,2 blank) then 7; exactly two done pulses.
- Assert rst_n=0 mid-SHIFT of 5555 → outputs return to reset values immediately; after release the display shows 0 and no done pulse occurs.
- LZ_BLANK=0, in_data=−5 → seg shows 0,0,0,5 digits (40,40,40,12); dp=0 on the top digit.
